// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-through, write-around data cache controller.
// Address layout is {tag, index, offset}. A load hit returns data in the same
// cycle. A load miss fetches the whole block from memory. Every store is
// written through to memory, and it also updates the cached word when it hits.
// Optional feature: define DCACHE_STATS_EN to add the hit_count/miss_count
// output ports and their counters.
module dcache_ctrl #(
  parameter int ADDR_W   = 10,
  parameter int INDEX_W  = 5,
  parameter int OFFSET_W = 2,
  parameter int DATA_W   = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         Mem_read,
  input  logic                         Mem_Write,
  input  logic [ADDR_W-1:0]            addr,
  input  logic [DATA_W-1:0]            wdata,
  output logic [DATA_W-1:0]            rdata,
  output logic                         stall,
  output logic                         mem_rd_req,
  output logic                         mem_wr_req,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  input  logic [(DATA_W<<OFFSET_W)-1:0] mem_rdata,
  input  logic                         mem_ready
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]                  hit_count,
  output logic [31:0]                  miss_count
`endif
);

  localparam int          TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int          LINES = 1 << INDEX_W;
  localparam int unsigned WORDS = 1 << OFFSET_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD_MISS,
    S_WR_MEM,
    S_WR_DONE
  } state_t;

  state_t state_q, state_d;

  logic [LINES-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES][WORDS];

  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic [TAG_W-1:0]    req_tag;
  logic [INDEX_W-1:0]  req_idx;
  logic [OFFSET_W-1:0] req_off;
  logic [TAG_W-1:0]    fill_tag;
  logic [INDEX_W-1:0]  fill_idx;
  logic                hit;
  logic                stall_c;
  logic                fill_we;
  logic                store_we;

  assign req_tag  = addr[ADDR_W-1 -: TAG_W];
  assign req_idx  = addr[OFFSET_W +: INDEX_W];
  assign req_off  = addr[OFFSET_W-1:0];
  // The fill target comes from the latched block address. The requester holds
  // addr stable during the miss, but the latched copy is the one that memory saw.
  assign fill_tag = mem_addr_q[ADDR_W-1 -: TAG_W];
  assign fill_idx = mem_addr_q[OFFSET_W +: INDEX_W];

  assign hit   = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign rdata = data_q[req_idx][req_off];

  // The IDLE stall is combinational on the request. It is gated by reset so
  // that an abort drops stall immediately, even if the request is still held.
  assign stall      = stall_c & rst_n;
  assign mem_rd_req = (state_q == S_RD_MISS);
  assign mem_wr_req = (state_q == S_WR_MEM);
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

  // Next-state logic, stall generation, memory request latching and valid updates
  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    stall_c     = 1'b0;
    fill_we     = 1'b0;
    store_we    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Mem_Write) begin
          stall_c     = 1'b1;
          mem_addr_d  = addr;
          mem_wdata_d = wdata;
          store_we    = hit;
          state_d     = S_WR_MEM;
        end else if (Mem_read && !hit) begin
          stall_c    = 1'b1;
          mem_addr_d = {req_tag, req_idx, {OFFSET_W{1'b0}}};
          state_d    = S_RD_MISS;
        end
      end
      S_RD_MISS: begin
        stall_c = 1'b1;
        if (mem_ready) begin
          fill_we           = 1'b1;
          valid_d[fill_idx] = 1'b1;
          state_d           = S_IDLE;
        end
      end
      S_WR_MEM: begin
        stall_c = 1'b1;
        if (mem_ready) begin
          state_d = S_WR_DONE;
        end
      end
      S_WR_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control state: FSM, valid bits and the registered memory request fields
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      valid_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Tag and data arrays are not reset. A fill replaces the whole line, and a
  // store hit patches a single word.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_q[fill_idx] <= fill_tag;
      for (int unsigned w = 0; w < WORDS; w++) begin
        data_q[fill_idx][w] <= mem_rdata[w*DATA_W +: DATA_W];
      end
    end else if (store_we) begin
      data_q[req_idx][req_off] <= wdata;
    end
  end

`ifdef DCACHE_STATS_EN
  logic        hit_inc;
  logic        miss_inc;
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  // Only IDLE load decisions are counted. The replay after a fill is a hit,
  // and stores are never counted.
  always_comb begin
    hit_inc      = (state_q == S_IDLE) && Mem_read && !Mem_Write && hit;
    miss_inc     = (state_q == S_IDLE) && Mem_read && !Mem_Write && !hit;
    hit_count_d  = hit_inc  ? hit_count_q  + 32'd1 : hit_count_q;
    miss_count_d = miss_inc ? miss_count_q + 32'd1 : miss_count_q;
  end

  // Statistics counters, wrapping modulo 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: table-driven directed bench for dcache_ctrl. Each table row
// is one clock cycle. It gives the inputs and the expected outputs, which are
// sampled mid-cycle. A hand-written sequence covers the reset abort during a
// miss. It also checks the stats counters when DCACHE_STATS_EN is defined.
module tb_dcache_ctrl;

  logic         clk;
  logic         rst_n;
  logic         Mem_read;
  logic         Mem_Write;
  logic [9:0]   addr;
  logic [31:0]  wdata;
  logic [31:0]  rdata;
  logic         stall;
  logic         mem_rd_req;
  logic         mem_wr_req;
  logic [9:0]   mem_addr;
  logic [31:0]  mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;
`endif

  dcache_ctrl #(
    .ADDR_W  (10),
    .INDEX_W (5),
    .OFFSET_W(2),
    .DATA_W  (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Mem_read  (Mem_read),
    .Mem_Write (Mem_Write),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .stall     (stall),
    .mem_rd_req(mem_rd_req),
    .mem_wr_req(mem_wr_req),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rd;
    logic         wr;
    logic [9:0]   a;
    logic [31:0]  wd;
    logic         rdy;
    logic [127:0] blk;
    logic         e_stall;
    logic         e_rreq;
    logic         e_wreq;
    logic [9:0]   e_maddr;
    logic [31:0]  e_mwd;
    logic         chk_rd;
    logic [31:0]  e_rdata;
  } vec_t;

  vec_t vecs[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  localparam logic [31:0] D0 = 32'h1000_00A0, D1 = 32'h1000_00A1,
                          D2 = 32'h1000_00A2, D3 = 32'h1000_00A3;
  localparam logic [31:0] E0 = 32'h2000_00E0, E1 = 32'h2000_00E1,
                          E2 = 32'h2000_00E2, E3 = 32'h2000_00E3;
  localparam logic [31:0] F0 = 32'h3000_00F0, F1 = 32'h3000_00F1,
                          F2 = 32'h3000_00F2, F3 = 32'h3000_00F3;
  localparam logic [127:0] BLK_D = {D3, D2, D1, D0};
  localparam logic [127:0] BLK_E = {E3, E2, E1, E0};
  localparam logic [127:0] BLK_F = {F3, F2, F1, F0};
  localparam logic [127:0] BLK_X = {4{32'hBAAD_BAAD}};
  localparam logic [31:0]  WB = 32'hDEAD_BEEF;
  localparam logic [31:0]  WC = 32'h0BAD_F00D;
  localparam logic [31:0]  WA = 32'h5555_AAAA;

  function automatic vec_t mk(input logic rd, input logic wr, input logic [9:0] a,
                              input logic [31:0] wd, input logic rdy, input logic [127:0] blk,
                              input logic es, input logic err, input logic ewr,
                              input logic [9:0] ema, input logic [31:0] emw,
                              input logic crd, input logic [31:0] erd);
    vec_t v;
    v.rd = rd; v.wr = wr; v.a = a; v.wd = wd; v.rdy = rdy; v.blk = blk;
    v.e_stall = es; v.e_rreq = err; v.e_wreq = ewr; v.e_maddr = ema;
    v.e_mwd = emw; v.chk_rd = crd; v.e_rdata = erd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [9:0] a,
                       input logic [31:0] wd, input logic rdy, input logic [127:0] blk);
    Mem_read = rd; Mem_Write = wr; addr = a; wdata = wd; mem_ready = rdy; mem_rdata = blk;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    drive(0, 0, 10'h000, 32'h0, 0, '0);

    // Line 9 (tag 0): miss and fill, hits, ignored idle mem_ready, store hit with WR_DONE hold
    vecs.push_back(mk(1,0,10'h024,0 ,0,'0   , 1,0,0,10'h000,0 ,0,0));
    vecs.push_back(mk(1,0,10'h024,0 ,0,'0   , 1,1,0,10'h024,0 ,0,0));
    vecs.push_back(mk(1,0,10'h024,0 ,0,'0   , 1,1,0,10'h024,0 ,0,0));
    vecs.push_back(mk(1,0,10'h024,0 ,1,BLK_D, 1,1,0,10'h024,0 ,0,0));
    vecs.push_back(mk(1,0,10'h024,0 ,0,'0   , 0,0,0,10'h024,0 ,1,D0));
    vecs.push_back(mk(1,0,10'h025,0 ,1,BLK_X, 0,0,0,10'h024,0 ,1,D1));
    vecs.push_back(mk(0,1,10'h026,WB,0,'0   , 1,0,0,10'h024,0 ,0,0));
    vecs.push_back(mk(0,1,10'h026,WB,0,'0   , 1,0,1,10'h026,WB,0,0));
    vecs.push_back(mk(0,1,10'h026,WB,1,'0   , 1,0,1,10'h026,WB,0,0));
    vecs.push_back(mk(0,1,10'h026,WB,0,'0   , 0,0,0,10'h026,WB,1,WB));
    vecs.push_back(mk(1,0,10'h026,0 ,0,'0   , 0,0,0,10'h026,WB,1,WB));
    vecs.push_back(mk(1,0,10'h027,0 ,0,'0   , 0,0,0,10'h026,WB,1,D3));
    // Store miss to 0x300 (no allocate), then a load miss with block-aligned fetch
    vecs.push_back(mk(0,1,10'h300,WC,0,'0   , 1,0,0,10'h026,WB,0,0));
    vecs.push_back(mk(0,1,10'h300,WC,1,'0   , 1,0,1,10'h300,WC,0,0));
    vecs.push_back(mk(0,1,10'h300,WC,0,'0   , 0,0,0,10'h300,WC,0,0));
    vecs.push_back(mk(1,0,10'h302,0 ,0,'0   , 1,0,0,10'h300,WC,0,0));
    vecs.push_back(mk(1,0,10'h302,0 ,1,BLK_E, 1,1,0,10'h300,WC,0,0));
    vecs.push_back(mk(1,0,10'h301,0 ,0,'0   , 0,0,0,10'h300,WC,1,E1));
    // Index 9 conflict: tag 2 evicts tag 0, which then misses again
    vecs.push_back(mk(1,0,10'h124,0 ,0,'0   , 1,0,0,10'h300,WC,0,0));
    vecs.push_back(mk(1,0,10'h124,0 ,1,BLK_F, 1,1,0,10'h124,WC,0,0));
    vecs.push_back(mk(1,0,10'h124,0 ,0,'0   , 0,0,0,10'h124,WC,1,F0));
    vecs.push_back(mk(1,0,10'h024,0 ,0,'0   , 1,0,0,10'h124,WC,0,0));
    vecs.push_back(mk(1,0,10'h024,0 ,1,BLK_D, 1,1,0,10'h024,WC,0,0));
    vecs.push_back(mk(1,0,10'h026,0 ,0,'0   , 0,0,0,10'h024,WC,1,D2));
    // Read and write both high: treated as a store hit
    vecs.push_back(mk(1,1,10'h025,WA,0,'0   , 1,0,0,10'h024,WC,0,0));
    vecs.push_back(mk(1,1,10'h025,WA,1,'0   , 1,0,1,10'h025,WA,0,0));
    vecs.push_back(mk(1,1,10'h025,WA,0,'0   , 0,0,0,10'h025,WA,1,WA));
    vecs.push_back(mk(1,0,10'h025,0 ,0,'0   , 0,0,0,10'h025,WA,1,WA));

    // Reset state
    repeat (2) @(negedge clk);
    #2;
    chk("reset.stall",      {31'b0, stall},      32'd0);
    chk("reset.mem_rd_req", {31'b0, mem_rd_req}, 32'd0);
    chk("reset.mem_wr_req", {31'b0, mem_wr_req}, 32'd0);
    chk("reset.mem_addr",   {22'b0, mem_addr},   32'd0);
    chk("reset.mem_wdata",  mem_wdata,           32'd0);
`ifdef DCACHE_STATS_EN
    chk("reset.hit_count",  hit_count,  32'd0);
    chk("reset.miss_count", miss_count, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].wd, vecs[i].rdy, vecs[i].blk);
      #2;
      chk($sformatf("v%0d.stall", i),      {31'b0, stall},      {31'b0, vecs[i].e_stall});
      chk($sformatf("v%0d.mem_rd_req", i), {31'b0, mem_rd_req}, {31'b0, vecs[i].e_rreq});
      chk($sformatf("v%0d.mem_wr_req", i), {31'b0, mem_wr_req}, {31'b0, vecs[i].e_wreq});
      chk($sformatf("v%0d.mem_addr", i),   {22'b0, mem_addr},   {22'b0, vecs[i].e_maddr});
      chk($sformatf("v%0d.mem_wdata", i),  mem_wdata,           vecs[i].e_mwd);
      if (vecs[i].chk_rd) chk($sformatf("v%0d.rdata", i), rdata, vecs[i].e_rdata);
`ifdef DCACHE_STATS_EN
      if (i == 6) begin
        chk("stats.first_hit_count",  hit_count,  32'd2);
        chk("stats.first_miss_count", miss_count, 32'd1);
      end
`endif
    end
`ifdef DCACHE_STATS_EN
    @(negedge clk);
    drive(0, 0, 10'h000, 32'h0, 0, '0);
    #2;
    chk("stats.final_hit_count",  hit_count,  32'd8);
    chk("stats.final_miss_count", miss_count, 32'd4);
`endif

    // Reset in the middle of a miss aborts the miss, and the line must stay invalid
    @(negedge clk);
    drive(1, 0, 10'h124, 32'h0, 0, '0);
    @(negedge clk);
    #2;
    chk("abort.pre_rd_req", {31'b0, mem_rd_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort.stall",    {31'b0, stall},      32'd0);
    chk("abort.rd_req",   {31'b0, mem_rd_req}, 32'd0);
    chk("abort.mem_addr", {22'b0, mem_addr},   32'd0);
    mem_ready = 1'b1;
    mem_rdata = BLK_F;
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 0, 10'h024, 32'h0, 0, '0);
    #2;
    chk("abort.post_miss_stall", {31'b0, stall}, 32'd1);
    n = 0;
    while (!mem_rd_req && n < 8) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("abort.post_rd_req",   {31'b0, mem_rd_req}, 32'd1);
    chk("abort.post_mem_addr", {22'b0, mem_addr},   32'h024);
    mem_ready = 1'b1;
    mem_rdata = BLK_D;
    @(negedge clk);
    mem_ready = 1'b0;
    #2;
    chk("abort.replay_stall", {31'b0, stall}, 32'd0);
    chk("abort.replay_rdata", rdata,          D0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-through, write-around data cache controller. It is the responder to the pipeline's `Mem_read`/`Mem_Write` memory requests and sits between the MEM stage and a slow main memory. It returns load data on hits in the same cycle. On misses and on every store it raises `stall` and runs a request/ready handshake to main memory.

## Interface
- `ADDR_W`, 10: word address width (1K words).
- `INDEX_W`, 5: line index width (32 lines).
- `OFFSET_W`, 2: word-in-block width (4 words per block); tag width = `ADDR_W-INDEX_W-OFFSET_W` (3).
- `DATA_W`, 32: word width.
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `Mem_read` in 1: load request from the decoder path.
- `Mem_Write` in 1: store request.
- `addr` in `ADDR_W`: word address, laid out as {tag, index, offset}.
- `wdata` in `DATA_W`: store data.
- `rdata` out `DATA_W`: load data, combinational from the array.
- `stall` out 1: freeze pipeline; requester holds `addr`/`wdata`/`Mem_*` stable while high.
- `mem_rd_req` out 1: block read request to main memory.
- `mem_wr_req` out 1: word write request to main memory.
- `mem_addr` out `ADDR_W`: registered; block-aligned (offset=0) for reads, full word address for writes.
- `mem_wdata` out `DATA_W`: registered store data.
- `mem_rdata` in `4*DATA_W`: fill block, word 0 in bits [31:0]; valid only with `mem_ready`.
- `mem_ready` in 1: one-cycle completion pulse from memory.

## Operation
- Storage: 32 lines, each with a valid bit, a 3-bit tag and 4 words. Hit = valid && tag match at `addr` index.
- FSM states and transitions:
  - IDLE: idle, or servicing a hit.
    - Load hit: `rdata` = addressed word, `stall`=0, stay in IDLE.
    - Load miss: `stall`=1, latch block address into `mem_addr`, go to RD_MISS.
    - Store: `stall`=1, latch `addr`/`wdata`, go to WR_MEM. On a store hit, the cached word is updated at this edge. On a store miss, there is no allocate.
  - RD_MISS: `mem_rd_req`=1, `stall`=1. On `mem_ready`, write `mem_rdata` into the line, set valid, write tag, and go to IDLE. The replayed access then hits.
  - WR_MEM: `mem_wr_req`=1, `stall`=1. On `mem_ready`, go to WR_DONE.
  - WR_DONE: `stall`=0 for one cycle, request inputs ignored, back to IDLE. This lets the stalled store retire without being reissued.
- `Mem_read` and `Mem_Write` both high: treated as a store; the read is ignored.
- `mem_ready` outside RD_MISS/WR_MEM is ignored.
- A fill replaces the line unconditionally. There is no dirty state, because memory is always current.
- `rdata` is don't-care unless a load hit is presented. The implementation drives the addressed array word.

## Timing
- Reset values (async on `rst_n` low): state IDLE; all valid bits 0; `stall`, `mem_rd_req`, `mem_wr_req` 0; `mem_addr`, `mem_wdata` 0; counters 0. Data/tag arrays are not reset.
- Load hit: 0 stall cycles.
- Load miss with `mem_ready` at cycle k (request first visible in cycle 1, k≥1):
  - `stall` high in cycles 0..k.
  - Cycle k+1 is a hit with `stall`=0.
- Store with `mem_ready` at cycle k:
  - `stall` high in cycles 0..k.
  - Cycle k+1 is WR_DONE with `stall`=0.
- `mem_*_req` are Moore outputs of RD_MISS/WR_MEM and drop in the cycle after `mem_ready`.
- Reset mid-miss or mid-write aborts the transaction. Requests drop immediately and no line is written.

## Configuration
- `DCACHE_STATS_EN`: defined adds output ports `hit_count` and `miss_count` (32 bits each). Each wraps modulo 2^32 and is reset to 0.
  - `hit_count` increments once per load hit, counted in IDLE only, so the replay after a fill counts as a hit.
  - `miss_count` increments once per load miss on entry to RD_MISS.
  - Stores are not counted.
- Undefined: the ports and counters are absent, and all other behaviour is identical.

## Test plan
- Reset, then load at 0x024 with `mem_ready` at k=3 and `mem_rdata`={D3,D2,D1,D0} → `mem_rd_req` high cycles 1..3 with `mem_addr`=0x024; `stall` high 4 cycles; `rdata`=D0 at cycle 4. A following load at 0x025 → D1 with no stall.
- Store 0xDEADBEEF to 0x026 after that fill → `mem_wr_req` with `mem_addr`=0x026 and `mem_wdata`=0xDEADBEEF; WR_DONE lasts one cycle. A following load at 0x026 → 0xDEADBEEF, 0 stall.
- Store to uncached 0x300 → memory write occurs. A following load at 0x300 misses (no allocate).
- Load 0x124 (same index 9, tag 2) → miss and refill. A following load at 0x024 misses again.
- Assert `rst_n` low during RD_MISS → `stall` and `mem_rd_req` drop immediately. After release, a load at 0x024 misses.
- With `DCACHE_STATS_EN` defined, run the first scenario plus one hit → `hit_count`=2, `miss_count`=1.
